sign_extend: RTL and testbench
==============================

Name: sign_extend

Overview:
Immediate-extension unit for the Simple_CPU datapath. It widens a 16-bit instruction immediate to the 32-bit datapath width.
- Combinational output feeds the ALU B-mux and branch adder in the same cycle.
- Registered copy with a valid flag serves the pipelined datapath variant.
- Default mode is classic two's-complement sign extension.

Parameters:
- IN_W, 16, immediate input width.
- OUT_W, 32, extended output width; must be greater than IN_W.

Ports:
- clk  input  1  rising-edge clock for registered outputs
- rst  input  1  asynchronous, active-high reset
- in  input  IN_W  immediate field from the instruction
- mode  input  2  extension select; tie to 2'b00 for plain sign extension
- in_valid  input  1  qualifies in/mode for capture into the registered path
- out  output  OUT_W  combinational extended value
- out_q  output  OUT_W  registered extended value
- out_valid  output  1  registered in_valid

Behaviour:
- Combinational path: out depends only on in and mode. No dependency on clk or rst. It settles within the same delta/time step.
- Mode encoding:
  - mode=00, sign extend: out = {{(OUT_W-IN_W){in[IN_W-1]}}, in}.
  - mode=01, zero extend: out = {{(OUT_W-IN_W){1'b0}}, in}.
  - mode=10, branch offset: sign extend, then shift left 2. out = {sext(in)[OUT_W-3:0], 2'b00}. The upper sign bits shifted out are discarded.
  - mode=11, upper immediate: out = {in, {(OUT_W-IN_W){1'b0}}}. For OUT_W=32 this is in<<16.
- Extension boundaries: in[IN_W-1]=0 yields zero fill in modes 00 and 10. in[IN_W-1]=1 yields ones fill in modes 00 and 10. 16'h8000 is the most negative value. 16'h7FFF is the most positive.
- Registered path:
  - On each rising clk with rst low: out_valid <= in_valid.
  - If in_valid=1, out_q <= out, i.e. the combinational value for the current in/mode.
  - If in_valid=0, out_q holds its previous value.
  - Latency is 1 cycle from in_valid to out_q/out_valid.
- Reset:
  - rst=1 forces out_q=0 and out_valid=0 immediately, without waiting for clk. Both hold while rst is high.
  - out is unaffected by rst.
  - Reset deasserted mid-stream: the first capture occurs at the first rising clk after rst falls.
- No internal state other than out_q and out_valid. No X propagation from mode when mode is a known value.

Test Plan:
- mode=00, in=16'h1234 -> out=32'h0000_1234 within 5 time units, no clock required.
- mode=00, in=16'hABCD -> out=32'hFFFF_ABCD. Also check in=16'h8000 -> 32'hFFFF_8000 and in=16'h7FFF -> 32'h0000_7FFF.
- mode=01, in=16'hABCD -> 32'h0000_ABCD. mode=11, in=16'hABCD -> 32'hABCD_0000.
- mode=10, in=16'hFFFF -> 32'hFFFF_FFFC. mode=10, in=16'h0001 -> 32'h0000_0004.
- Registered path: in_valid=1, mode=00, in=16'hABCD. After one rising clk, out_q=32'hFFFF_ABCD and out_valid=1. Then in_valid=0 and in=16'h1234 for 2 clocks: out_q holds 32'hFFFF_ABCD and out_valid=0.
- Assert rst between clock edges while out_q is nonzero -> out_q=0 and out_valid=0 immediately. out still tracks in combinationally throughout.

Source files
------------

// File: rtl/sign_extend.sv
// Immediate-extension unit: widens an instruction immediate to datapath width.
// A combinational result feeds same-cycle consumers; a registered copy with a
// valid flag serves the pipelined datapath.
module sign_extend #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out,
  output logic [OUT_W-1:0] out_q,
  output logic             out_valid
);

  localparam int unsigned EXT_W = OUT_W - IN_W;

  localparam logic [1:0] MODE_SEXT   = 2'b00;
  localparam logic [1:0] MODE_ZEXT   = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;
  localparam logic [1:0] MODE_UPPER  = 2'b11;

  // Reject parameterisations where there is nothing to extend into.
  if (OUT_W <= IN_W) begin : g_bad_width
    $error("sign_extend: OUT_W must be greater than IN_W");
  end

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;

  // Shared sign- and zero-extended forms of the immediate.
  always_comb begin
    sext = {{EXT_W{in[IN_W-1]}}, in};
    zext = {{EXT_W{1'b0}}, in};
  end

  // Mode select; the branch form drops the two sign bits shifted out on top.
  always_comb begin
    out = sext;
    case (mode)
      MODE_SEXT:   out = sext;
      MODE_ZEXT:   out = zext;
      MODE_BRANCH: out = {sext[OUT_W-3:0], 2'b00};
      MODE_UPPER:  out = {in, {EXT_W{1'b0}}};
      default:     out = sext;
    endcase
  end

  // Registered copy: capture on valid, hold otherwise; valid is a 1-cycle delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= out;
      end
    end
  end

endmodule

// File: tb/tb_sign_extend.sv
// Self-checking bench for sign_extend: directed boundary values, randomized
// traffic against an arithmetic reference model, and an asynchronous reset.
module tb_sign_extend;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  in;
  logic [1:0]       mode;
  logic             in_valid;
  logic [OUT_W-1:0] out;
  logic [OUT_W-1:0] out_q;
  logic             out_valid;

  typedef struct packed {
    logic             v;
    logic [OUT_W-1:0] q;
  } exp_t;

  exp_t             sb[$];
  int               errors = 0;
  int               checks = 0;
  bit               mon_en = 1'b0;
  logic [OUT_W-1:0] model_q = '0;

  sign_extend #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .mode      (mode),
    .in_valid  (in_valid),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference: interpret the immediate as a signed integer and do plain arithmetic.
  function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] x);
    longint s;
    longint u;
    u = longint'(x);
    s = x[15] ? (u - 65536) : u;
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(s * 4);
      default: return 32'(u * 65536);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic comb_check(input string name, input logic [1:0] m,
                            input logic [15:0] x, input logic [31:0] exp);
    mode = m;
    in   = x;
    #1;
    check(name, out, exp);
  endtask

  // Set inputs for the next rising edge and record what it should produce.
  task automatic apply(input logic v, input logic [1:0] m, input logic [15:0] x);
    in_valid = v;
    mode     = m;
    in       = x;
    if (v) model_q = ref_ext(m, x);
    sb.push_back({v, model_q});
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] x);
    @(negedge clk);
    apply(v, m, x);
    #1;
    check("out_comb", out, ref_ext(m, x));
  endtask

  // Monitor: after each rising edge, pop the expected registered response.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en && sb.size() > 0) begin
      e = sb.pop_front();
      check("out_valid", 32'(out_valid), 32'(e.v));
      check("out_q", out_q, e.q);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] edge_vals [5];
    logic [15:0] x;
    edge_vals[0] = 16'h0000;
    edge_vals[1] = 16'h0001;
    edge_vals[2] = 16'h7FFF;
    edge_vals[3] = 16'h8000;
    edge_vals[4] = 16'hFFFF;

    rst      = 1'b1;
    in       = '0;
    mode     = 2'b00;
    in_valid = 1'b0;
    #2;
    check("reset_out_q", out_q, 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);

    // Combinational path, exercised while reset is still high.
    comb_check("sext_pos",   2'b00, 16'h1234, 32'h0000_1234);
    comb_check("sext_neg",   2'b00, 16'hABCD, 32'hFFFF_ABCD);
    comb_check("sext_min",   2'b00, 16'h8000, 32'hFFFF_8000);
    comb_check("sext_max",   2'b00, 16'h7FFF, 32'h0000_7FFF);
    comb_check("zext",       2'b01, 16'hABCD, 32'h0000_ABCD);
    comb_check("upper",      2'b11, 16'hABCD, 32'hABCD_0000);
    comb_check("branch_neg", 2'b10, 16'hFFFF, 32'hFFFF_FFFC);
    comb_check("branch_pos", 2'b10, 16'h0001, 32'h0000_0004);
    comb_check("branch_min", 2'b10, 16'h8000, 32'hFFFE_0000);
    check("reset_hold_q", out_q, 32'h0);

    @(negedge clk);
    rst     = 1'b0;
    model_q = '0;
    mon_en  = 1'b1;

    // Capture then hold for two cycles.
    drive(1'b1, 2'b00, 16'hABCD);
    drive(1'b0, 2'b00, 16'h1234);
    drive(1'b0, 2'b00, 16'h1234);

    // Randomized traffic, with boundary immediates mixed in.
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) x = edge_vals[$urandom_range(0, 4)];
      else                           x = 16'($urandom);
      drive(1'($urandom_range(0, 1)), 2'($urandom), x);
    end

    // Asynchronous reset between edges while out_q is nonzero.
    drive(1'b1, 2'b00, 16'hABCD);
    @(posedge clk);
    #3;
    check("pre_reset_q", out_q, 32'hFFFF_ABCD);
    rst    = 1'b1;
    mon_en = 1'b0;
    #1;
    check("async_rst_q", out_q, 32'h0);
    check("async_rst_valid", 32'(out_valid), 32'h0);
    comb_check("rst_comb_track", 2'b00, 16'h8001, 32'hFFFF_8001);
    @(posedge clk);
    #1;
    check("rst_held_q", out_q, 32'h0);
    check("rst_held_valid", 32'(out_valid), 32'h0);
    sb.delete();
    model_q = '0;

    // First capture happens at the first rising edge after release.
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    apply(1'b1, 2'b10, 16'hFFFF);

    repeat (60) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom));
    end
    drive(1'b0, 2'b01, 16'h0000);
    drive(1'b0, 2'b11, 16'hFFFF);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
